// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer driving one external 1-bit ALU slice, LSB first
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             slice_a,
    output logic             slice_bin,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    count;
    logic             carry, cin_msb, cout_msb;
    // set once the MSB has been processed; RUN keeps one settle cycle before DONE
    logic             tail;
    logic             active, last, accept;

    assign accept = (state == IDLE) && in_valid;
    assign active = (state == RUN) && !tail;
    assign last   = count == IW'(WIDTH - 1);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (tail) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // outputs: handshake, slice drive (zero outside active bit cycles) and result flags
    always_comb begin
        in_ready     = state == IDLE;
        out_valid    = state == DONE;
        slice_a      = active & a_q[count];
        slice_bin    = active & b_q[count];
        slice_cin    = active & carry;
        slice_less   = 1'b0;
        slice_op     = active ? op_q : 3'b000;
        out_result   = result_q;
        out_zero     = result_q == '0;
        out_overflow = (op_q[1:0] == 2'b10) & (cin_msb ^ cout_msb);
    end

    // operand capture at the handshake, then one result bit and carry per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            count    <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            tail     <= 1'b0;
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            op_q     <= in_op;
            result_q <= '0;
            count    <= '0;
            carry    <= in_op[2];
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            tail     <= 1'b0;
        end else if (active) begin
            result_q[count] <= slice_result;
            carry           <= slice_cout;
            count           <= count + 1'b1;
            if (last) begin
                cin_msb  <= carry;
                cout_msb <= slice_cout;
                tail     <= 1'b1;
                // SLT: bit 0 takes the raw sign of a-b from the MSB slice
                if (op_q[1:0] == 2'b11) result_q[0] <= slice_set;
            end
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq with a behavioural 1-bit slice
module tb_alu_serial_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [2:0]   in_op = '0;
    logic         slice_a, slice_bin, slice_cin, slice_less;
    logic [2:0]   slice_op;
    logic         slice_result, slice_cout, slice_set;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zero, out_overflow;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         v;
    } exp_t;

    exp_t sb[$];

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .slice_a(slice_a), .slice_bin(slice_bin), .slice_cin(slice_cin),
        .slice_less(slice_less), .slice_op(slice_op),
        .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    // external 1-bit ALU slice: inverts B itself, full adder, 4-way select
    logic bx, sum;
    always_comb begin
        bx         = slice_op[2] ^ slice_bin;
        sum        = slice_a ^ bx ^ slice_cin;
        slice_cout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
        slice_set  = sum;
        slice_result = (slice_op[1:0] == 2'b00) ? (slice_a & bx) :
                       (slice_op[1:0] == 2'b01) ? (slice_a | bx) :
                       (slice_op[1:0] == 2'b10) ? sum : slice_less;
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb = op[2] ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[2]};
        case (op[1:0])
            2'b00:   e.r = a & bb;
            2'b01:   e.r = a | bb;
            2'b10:   e.r = s[W-1:0];
            default: e.r = {{(W-1){1'b0}}, s[W-1]};
        endcase
        e.z = e.r == '0;
        e.v = (op[1:0] == 2'b10) && (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // drive one operation, optionally stall in DONE, and compare against the scoreboard
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input int stall, input string name);
        exp_t e;
        int cyc;
        logic [W-1:0] held;
        sb.push_back(model(a, b, op));
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        vectors++;
        if (cyc != W + 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, W + 1);
        end
        if (!out_valid) return;
        vectors++;
        if (out_result !== e.r || out_zero !== e.z || out_overflow !== e.v) begin
            miscompares++;
            $display("FAIL %s result: got r=%h z=%b v=%b want r=%h z=%b v=%b",
                     name, out_result, out_zero, out_overflow, e.r, e.z, e.v);
        end
        held = out_result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = b + 8'd1; in_op = 3'b001;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held) begin
                miscompares++;
                $display("FAIL %s stall %0d: got valid=%b ready=%b r=%h want valid=1 ready=0 r=%h",
                         name, i, out_valid, in_ready, out_result, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: got ready=%b valid=%b want ready=1 valid=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_zero !== 1'b1 ||
            out_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset outputs: got ready=%b valid=%b r=%h z=%b v=%b want 1 0 00 1 0",
                     in_ready, out_valid, out_result, out_zero, out_overflow);
        end
        vectors++;
        if ({slice_a, slice_bin, slice_cin, slice_less, slice_op} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset slice: got %b want 0000000", {slice_a, slice_bin, slice_cin, slice_less, slice_op});
        end
        reset = 1'b0;
    endtask

    task automatic test_add_sub;
        run_op(8'h05, 8'h03, 3'b010, 0, "add_5_3");
        run_op(8'h03, 8'h05, 3'b110, 0, "sub_3_5");
        run_op(8'h05, 8'h05, 3'b110, 0, "sub_5_5");
    endtask

    task automatic test_logic_slt;
        run_op(8'h03, 8'h05, 3'b111, 0, "slt_3_5");
        run_op(8'h05, 8'h03, 3'b111, 0, "slt_5_3");
        run_op(8'hF0, 8'h3C, 3'b000, 0, "and");
        run_op(8'hF0, 8'h3C, 3'b001, 0, "or");
    endtask

    task automatic test_overflow;
        run_op(8'h7F, 8'h01, 3'b010, 0, "add_ovf");
        run_op(8'h80, 8'h01, 3'b110, 0, "sub_ovf");
        run_op(8'h7F, 8'h7F, 3'b000, 0, "and_no_ovf");
    endtask

    task automatic test_backpressure;
        run_op(8'h12, 8'h34, 3'b010, 5, "backpressure");
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL backpressure extra: got valid=%b pending=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        in_a = 8'h55; in_b = 8'h22; in_op = 3'b010; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || slice_op !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_run: got ready=%b valid=%b op=%b want 1 0 000", in_ready, out_valid, slice_op);
        end
        repeat (W + 3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run emitted: got valid=%b want 0", out_valid);
        end
        run_op(8'h21, 8'h13, 3'b010, 0, "add_after_reset");
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b;
        logic [2:0]   op;
        for (int i = 0; i < 12; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom_range(0, 7));
            run_op(a, b, op, i % 3, "random");
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_logic_slt;
        test_overflow;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
